// File: rtl/dsp_ctrl_pkg.sv
// Shared encodings and defaults for the filter/bypass switch sequencer.
package dsp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BYPASS = 2'b00,
        ST_FLUSH  = 2'b01,
        ST_WARMUP = 2'b10,
        ST_ACTIVE = 2'b11
    } ctrl_state_t;

    localparam int DEF_LGDLY        = 8;
    localparam int DEF_FLUSH_CYCLES = 2;

endpackage

// File: rtl/dspswitch_ctrl_if.sv
// Control-register side and datapath side signals of the switch sequencer.
interface dspswitch_ctrl_if
    import dsp_ctrl_pkg::*;
#(
    parameter int LGDLY = DEF_LGDLY
);
    logic             i_request;
    logic             i_ce;
    logic [LGDLY-1:0] i_delay;
    logic             o_filter_reset;
    logic             o_en;
    logic             o_busy;
    logic             o_switched;

    modport master (
        output i_request, i_ce, i_delay,
        input  o_filter_reset, o_en, o_busy, o_switched
    );

    modport slave (
        input  i_request, i_ce, i_delay,
        output o_filter_reset, o_en, o_busy, o_switched
    );
endinterface

// File: rtl/dspswitch_ctrl.sv
// Sequences filter enable: flush, warm up for i_delay valid samples, then select filtered path.
// Latency: outputs registered, FLUSH_CYCLES edges flush then i_delay i_ce strobes to o_en.
// Backpressure: none; i_request level is obeyed every cycle, disable takes effect at the next edge.
module dspswitch_ctrl
    import dsp_ctrl_pkg::*;
#(
    parameter int LGDLY        = DEF_LGDLY,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
)(
    input  logic             i_clk,
    input  logic             i_areset_n,
    dspswitch_ctrl_if.slave  bus
);

    localparam int             FW         = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FW-1:0]  FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [LGDLY-1:0] WU_LAST  = LGDLY'(1);

    ctrl_state_t      state, state_nxt;
    logic [FW-1:0]    flush_cnt, flush_cnt_nxt;
    logic [LGDLY-1:0] wu_cnt, wu_cnt_nxt;
    logic             en_nxt;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        wu_cnt_nxt    = wu_cnt;
        case (state)
            ST_BYPASS: begin
                if (bus.i_request) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = '0;
                end
            end
            ST_FLUSH: begin
                if (!bus.i_request) begin
                    state_nxt = ST_BYPASS;
                end else if (flush_cnt == FLUSH_LAST) begin
                    // i_delay is frozen here; later changes must not disturb the warm-up
                    wu_cnt_nxt = bus.i_delay;
                    state_nxt  = (bus.i_delay == '0) ? ST_ACTIVE : ST_WARMUP;
                end else begin
                    flush_cnt_nxt = flush_cnt + 1'b1;
                end
            end
            ST_WARMUP: begin
                if (!bus.i_request) begin
                    state_nxt = ST_BYPASS;
                end else if (bus.i_ce) begin
                    wu_cnt_nxt = wu_cnt - 1'b1;
                    if (wu_cnt == WU_LAST) begin
                        state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!bus.i_request) begin
                    state_nxt = ST_BYPASS;
                end
            end
            default: state_nxt = ST_BYPASS;
        endcase
        en_nxt = (state_nxt == ST_ACTIVE);
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state              <= ST_BYPASS;
            flush_cnt          <= '0;
            wu_cnt             <= '0;
            bus.o_filter_reset <= 1'b1;
            bus.o_en           <= 1'b0;
            bus.o_busy         <= 1'b0;
            bus.o_switched     <= 1'b0;
        end else begin
            state              <= state_nxt;
            flush_cnt          <= flush_cnt_nxt;
            wu_cnt             <= wu_cnt_nxt;
            bus.o_filter_reset <= (state_nxt == ST_BYPASS) || (state_nxt == ST_FLUSH);
            bus.o_en           <= en_nxt;
            bus.o_busy         <= (state_nxt == ST_FLUSH) || (state_nxt == ST_WARMUP);
            bus.o_switched     <= en_nxt ^ bus.o_en;
        end
    end

endmodule

// File: tb/tb_dspswitch_ctrl.sv
// Scoreboard bench for the filter/bypass switch sequencer.
module tb_dspswitch_ctrl;

    localparam int LGDLY        = 8;
    localparam int FLUSH_CYCLES = 2;

    logic i_clk      = 1'b0;
    logic i_areset_n = 1'b1;

    always #5 i_clk = ~i_clk;

    dspswitch_ctrl_if #(.LGDLY(LGDLY)) ctl();

    dspswitch_ctrl #(.LGDLY(LGDLY), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .bus        (ctl)
    );

    // {filter_reset, en, busy, switched}
    logic [3:0] obs;
    assign obs = {ctl.o_filter_reset, ctl.o_en, ctl.o_busy, ctl.o_switched};

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] sb_q[$];

    // Reference model: 0 bypass, 1 flush, 2 warm-up, 3 active
    int   m_st, m_fc, m_need, m_seen;
    logic m_en;

    task automatic model_reset();
        m_st = 0; m_fc = 0; m_need = 0; m_seen = 0; m_en = 1'b0;
    endtask

    // Drive one cycle of stimulus, predict the outputs after the edge, advance past the edge.
    task automatic drive(input logic req, input logic ce);
        logic       en_n;
        logic [3:0] exp;
        ctl.i_request = req;
        ctl.i_ce      = ce;
        case (m_st)
            0: if (req) begin m_st = 1; m_fc = 0; end
            1: begin
                if (!req) m_st = 0;
                else if (m_fc + 1 == FLUSH_CYCLES) begin
                    if (ctl.i_delay == 0) m_st = 3;
                    else begin m_st = 2; m_need = int'(ctl.i_delay); m_seen = 0; end
                end else m_fc++;
            end
            2: begin
                if (!req) m_st = 0;
                else if (ce) begin
                    m_seen++;
                    if (m_seen == m_need) m_st = 3;
                end
            end
            default: if (!req) m_st = 0;
        endcase
        en_n = (m_st == 3);
        exp  = {(m_st <= 1), en_n, (m_st == 1 || m_st == 2), (en_n != m_en)};
        m_en = en_n;
        sb_q.push_back(exp);
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        ctl.i_request = 1'b0;
        ctl.i_ce      = 1'b0;
        ctl.i_delay   = '0;
        #2 i_areset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (obs !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_vals: got %b want 1000", obs);
        end
        repeat (2) @(posedge i_clk);
        #1 i_areset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)));
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp || obs !== 4'b1000) begin
                n_err++;
                $display("FAIL idle_cyc%0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_warmup_ce3();
        logic [3:0] exp;
        logic       ce, prev_en;
        int samples = 0, rise_samples = -1, sw_cnt = 0, fr_cnt = 0;
        ctl.i_delay = 8'd5;
        for (int k = 0; k < 30; k++) begin
            ce = (k % 3 == 2);
            if (ctl.o_busy && !ctl.o_filter_reset && ce) samples++;
            prev_en = ctl.o_en;
            drive(1'b1, ce);
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL warm5_cyc%0d: got %b want %b", k, obs, exp);
            end
            if (ctl.o_switched) sw_cnt++;
            if (ctl.o_filter_reset) fr_cnt++;
            if (!prev_en && ctl.o_en && rise_samples < 0) rise_samples = samples;
        end
        n_cmp++;
        if (rise_samples != 5) begin
            n_err++;
            $display("FAIL warm5_samples: got %0d want 5", rise_samples);
        end
        n_cmp++;
        if (sw_cnt != 1) begin
            n_err++;
            $display("FAIL warm5_switched: got %0d want 1", sw_cnt);
        end
        n_cmp++;
        if (fr_cnt != FLUSH_CYCLES) begin
            n_err++;
            $display("FAIL warm5_flush_len: got %0d want %0d", fr_cnt, FLUSH_CYCLES);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0);
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL warm5_off%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_zero_delay();
        logic [3:0] exp;
        int first_en = -1;
        ctl.i_delay = '0;
        for (int e = 1; e <= 6; e++) begin
            drive(1'b1, 1'b0);
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL zero_edge%0d: got %b want %b", e, obs, exp);
            end
            if (ctl.o_en && first_en < 0) first_en = e;
        end
        n_cmp++;
        if (first_en != FLUSH_CYCLES + 1) begin
            n_err++;
            $display("FAIL zero_en_edge: got %0d want %0d", first_en, FLUSH_CYCLES + 1);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0);
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL zero_off%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] exp;
        logic       req_t[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        logic       ce_t[8]  = '{0, 0, 0, 1, 1, 0, 0, 0};
        int en_seen = 0, sw_cnt = 0;
        ctl.i_delay = 8'd4;
        for (int k = 0; k < 8; k++) begin
            drive(req_t[k], ce_t[k]);
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL abort_cyc%0d: got %b want %b", k, obs, exp);
            end
            if (ctl.o_en) en_seen++;
            if (ctl.o_switched) sw_cnt++;
            if (k == 5) begin
                n_cmp++;
                if (ctl.o_filter_reset !== 1'b1 || ctl.o_busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort_bypass: got fr=%b busy=%b want fr=1 busy=0",
                             ctl.o_filter_reset, ctl.o_busy);
                end
            end
        end
        n_cmp++;
        if (en_seen != 0 || sw_cnt != 0) begin
            n_err++;
            $display("FAIL abort_no_en: got en_cycles=%0d sw=%0d want 0/0", en_seen, sw_cnt);
        end
    endtask

    task automatic test_drop_with_ce();
        logic [3:0] exp;
        logic       req_t[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        logic       ce_t[8]  = '{0, 0, 0, 1, 0, 1, 0, 1};
        ctl.i_delay = 8'd1;
        for (int k = 0; k < 8; k++) begin
            drive(req_t[k], ce_t[k]);
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL drop_cyc%0d: got %b want %b", k, obs, exp);
            end
            if (k == 4) begin
                n_cmp++;
                if (obs !== 4'b0110 && obs !== 4'b0100) begin
                    n_err++;
                    $display("FAIL drop_active: got %b want fr=0 en=1", obs);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (obs !== 4'b1001) begin
                    n_err++;
                    $display("FAIL drop_edge: got %b want 1001", obs);
                end
            end
            if (k == 6) begin
                n_cmp++;
                if (ctl.o_switched !== 1'b0) begin
                    n_err++;
                    $display("FAIL drop_pulse_len: got %b want 0", ctl.o_switched);
                end
            end
        end
    endtask

    task automatic test_reset_midwarm();
        logic [3:0] exp;
        logic       prev_en;
        int samples = 0, rise_samples = -1;
        ctl.i_delay = 8'd200;
        for (int k = 0; k < 3 + 80; k++) begin
            drive(1'b1, 1'b1);
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL midrst_pre%0d: got %b want %b", k, obs, exp);
            end
        end
        #2 i_areset_n = 1'b0;
        ctl.i_request = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (obs !== 4'b1000) begin
            n_err++;
            $display("FAIL midrst_async: got %b want 1000", obs);
        end
        #2 i_areset_n = 1'b1;
        @(posedge i_clk);
        #1;
        n_cmp++;
        if (obs !== 4'b1000) begin
            n_err++;
            $display("FAIL midrst_after: got %b want 1000", obs);
        end
        for (int k = 0; k < 260; k++) begin
            if (k == 12) ctl.i_delay = 8'd7;
            if (ctl.o_busy && !ctl.o_filter_reset) samples++;
            prev_en = ctl.o_en;
            drive(1'b1, 1'b1);
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL midrst_cyc%0d: got %b want %b", k, obs, exp);
            end
            if (!prev_en && ctl.o_en && rise_samples < 0) rise_samples = samples;
        end
        n_cmp++;
        if (rise_samples != 200) begin
            n_err++;
            $display("FAIL midrst_samples: got %0d want 200", rise_samples);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_warmup_ce3();
        test_zero_delay();
        test_abort();
        test_drop_with_ce();
        test_reset_midwarm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
